// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state encodings and default width for the execute stage
package alu_pkg;

  localparam int W_DEFAULT = 8;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MUL_BUSY = 2'd1;
  localparam logic [1:0] ST_DIV_BUSY = 2'd2;

endpackage

// File: rtl/iter_muldiv_core.sv
// rtl/iter_muldiv_core.sv - iterative shift-add multiplier / restoring divider, one bit per cycle
module iter_muldiv_core
  import alu_pkg::*;
#(
  parameter int W    = W_DEFAULT,
  parameter int ITER = W
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start_i,
  input  logic           op_div_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic           step_i,
  output logic           last_o,
  output logic [2*W-1:0] result_o,
  output logic           divisor_zero_o
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  // acc_q holds {upper, lower}: MUL = {partial product, remaining multiplier bits},
  // DIV = {partial remainder, dividend bits shifting into quotient}.
  logic [2*W-1:0] acc_q, acc_d;
  // opnd_q is the multiplicand for MUL and the divisor for DIV.
  logic [W-1:0]   opnd_q;
  logic           div_q;
  logic [CW-1:0]  cnt_q;

  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic [2*W-1:0] mul_next;
  logic [2*W-1:0] div_next;

  // One iteration of either algorithm, selected by the latched operation
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    mul_next  = {mul_sum, acc_q[W-1:1]};
    div_shift = acc_q[2*W-1:W-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    if (div_diff[W]) begin
      div_next = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
    end else begin
      div_next = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    end
    acc_d = div_q ? div_next : mul_next;
  end

  // Operand latch on start, then one iteration per busy cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      acc_q  <= op_div_i ? {{W{1'b0}}, a_i} : {{W{1'b0}}, b_i};
      opnd_q <= op_div_i ? b_i : a_i;
      div_q  <= op_div_i;
      cnt_q  <= '0;
    end else if (step_i) begin
      acc_q  <= acc_d;
      cnt_q  <= last_o ? '0 : cnt_q + CW'(1);
    end
  end

  // The final iteration's value is handed out combinationally so the stage
  // can register it on the same edge that the iteration completes.
  assign last_o         = (cnt_q == LAST);
  assign result_o       = acc_d;
  assign divisor_zero_o = (opnd_q == '0);

endmodule

// File: rtl/ex_muldiv_stage.sv
// rtl/ex_muldiv_stage.sv - execute stage: single-cycle ALU plus iterative MUL/DIV with pipeline stall
module ex_muldiv_stage
  import alu_pkg::*;
#(
  parameter int W    = W_DEFAULT,
  parameter int ITER = W
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [3:0]     opcode_in,
  input  logic [W-1:0]   A_in,
  input  logic [W-1:0]   B_in,
  output logic           stall,
  output logic [2*W-1:0] result_out,
  output logic           valid_out,
  output logic           carry_out,
  output logic           zero_out,
  output logic           div0_out
);

  logic [1:0]     state_q, state_d;
  logic [2*W-1:0] result_q, result_d;
  logic           valid_q, valid_d;
  logic           carry_q, carry_d;
  logic           zero_q, zero_d;
  logic           div0_q, div0_d;

  logic           is_mul, is_div, core_start, core_last, core_b_zero;
  logic [2*W-1:0] core_res;
  logic [W:0]     add_sum, sub_diff;
  logic [W-1:0]   alu_res;
  logic           alu_carry, alu_valid;

  assign is_mul     = (opcode_in == OP_MUL);
  assign is_div     = (opcode_in == OP_DIV);
  assign core_start = (state_q == ST_IDLE) && (is_mul || is_div);

  iter_muldiv_core #(.W(W), .ITER(ITER)) u_core (
    .clk            (clk),
    .rstn           (rstn),
    .start_i        (core_start),
    .op_div_i       (is_div),
    .a_i            (A_in),
    .b_i            (B_in),
    .step_i         (state_q != ST_IDLE),
    .last_o         (core_last),
    .result_o       (core_res),
    .divisor_zero_o (core_b_zero)
  );

  // Single-cycle ALU; SUB carry is the borrow out of the W+1 bit difference
  always_comb begin
    add_sum   = {1'b0, A_in} + {1'b0, B_in};
    sub_diff  = {1'b0, A_in} - {1'b0, B_in};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_valid = 1'b1;
    case (opcode_in)
      OP_ADD: begin alu_res = add_sum[W-1:0];  alu_carry = add_sum[W];  end
      OP_SUB: begin alu_res = sub_diff[W-1:0]; alu_carry = sub_diff[W]; end
      OP_AND: alu_res = A_in & B_in;
      OP_OR:  alu_res = A_in | B_in;
      OP_XOR: alu_res = A_in ^ B_in;
      OP_SHL: alu_res = {A_in[W-2:0], 1'b0};
      OP_SHR: alu_res = {1'b0, A_in[W-1:1]};
      default: alu_valid = 1'b0;
    endcase
  end

  // FSM decode, stall and next output-register values; NOP leaves results untouched
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    div0_d   = div0_q;
    valid_d  = 1'b0;
    stall    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_mul) begin
          stall   = 1'b1;
          state_d = ST_MUL_BUSY;
        end else if (is_div) begin
          stall   = 1'b1;
          state_d = ST_DIV_BUSY;
        end else if (alu_valid) begin
          result_d = {{W{1'b0}}, alu_res};
          carry_d  = alu_carry;
          zero_d   = (alu_res == '0);
          div0_d   = 1'b0;
          valid_d  = 1'b1;
        end
      end
      ST_MUL_BUSY, ST_DIV_BUSY: begin
        // Dropping stall on the last iteration lets upstream advance on the
        // same edge the result is captured, so back-to-back ops lose no cycle.
        stall = !core_last;
        if (core_last) begin
          state_d  = ST_IDLE;
          result_d = core_res;
          carry_d  = 1'b0;
          zero_d   = (core_res == '0);
          div0_d   = (state_q == ST_DIV_BUSY) && core_b_zero;
          valid_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered result/flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      valid_q  <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      div0_q   <= div0_d;
    end
  end

  assign result_out = result_q;
  assign valid_out  = valid_q;
  assign carry_out  = carry_q;
  assign zero_out   = zero_q;
  assign div0_out   = div0_q;

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// tb/tb_ex_muldiv_stage.sv - scoreboard bench for ex_muldiv_stage with stall-aware upstream driver
module tb_ex_muldiv_stage;
  import alu_pkg::*;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [3:0]     opcode = OP_NOP;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           stall;
  logic [2*W-1:0] result;
  logic           valid, carry, zero, div0;

  always #5 clk = ~clk;

  ex_muldiv_stage #(.W(W), .ITER(W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .opcode_in  (opcode),
    .A_in       (a),
    .B_in       (b),
    .stall      (stall),
    .result_out (result),
    .valid_out  (valid),
    .carry_out  (carry),
    .zero_out   (zero),
    .div0_out   (div0)
  );

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        d;
  } instr_t;

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        d;
    int          cyc;
  } exp_t;

  instr_t prog[$];
  exp_t   sb[$];
  exp_t   me;
  int     tests = 0;
  int     fails = 0;
  int     cyc = 0;
  int     st;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic put(input logic [3:0] op, input logic [7:0] pa, input logic [7:0] pb,
                     input logic [15:0] res, input logic c, input logic z, input logic d);
    instr_t i;
    i.op = op; i.a = pa; i.b = pb; i.res = res; i.c = c; i.z = z; i.d = d;
    prog.push_back(i);
  endtask

  // Acts as the ID/EX register: an instruction stays at the inputs until
  // stall is seen low, then the next one is presented after the edge.
  task automatic run_prog(output int stalls);
    instr_t ins;
    exp_t   e;
    int     g;
    stalls = 0;
    while (prog.size() > 0) begin
      ins = prog.pop_front();
      @(posedge clk); #1;
      opcode = ins.op; a = ins.a; b = ins.b;
      if (ins.op >= OP_ADD && ins.op <= OP_DIV) begin
        e.res = ins.res; e.c = ins.c; e.z = ins.z; e.d = ins.d;
        e.cyc = cyc + ((ins.op >= OP_MUL) ? 9 : 1);
        sb.push_back(e);
      end
      @(negedge clk);
      g = 0;
      while (stall === 1'b1 && g < 20) begin
        stalls++;
        g++;
        @(negedge clk);
      end
      if (g >= 20) begin
        tests++;
        fails++;
        $display("FAIL stall_timeout: stall still 1 after %0d cycles, required release", g);
      end
    end
    @(posedge clk); #1;
    opcode = OP_NOP; a = '0; b = '0;
    repeat (12) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (valid === 1'b1) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid: valid_out=1 at cycle %0d, required 0", cyc);
          end else begin
            me = sb.pop_front();
            chk("result", result, me.res);
            chk("carry", carry, me.c);
            chk("zero", zero, me.z);
            chk("div0", div0, me.d);
            chk("valid_cycle", cyc, me.cyc);
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_valid", valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_carry", carry, 0);
    chk("rst_zero", zero, 0);
    chk("rst_div0", div0, 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    put(OP_ADD, 8'hF0, 8'h20, 16'h0010, 1, 0, 0);
    run_prog(st);
    chk("add_stall_cycles", st, 0);

    put(OP_MUL, 8'hC8, 8'hC8, 16'h9C40, 0, 0, 0);
    run_prog(st);
    chk("mul_stall_cycles", st, 8);

    put(OP_DIV, 8'd100, 8'd7, 16'h020E, 0, 0, 0);
    put(OP_DIV, 8'h55, 8'h00, 16'h55FF, 0, 0, 1);
    run_prog(st);
    chk("div_div_stall_cycles", st, 16);

    put(OP_MUL, 8'h0F, 8'h11, 16'h00FF, 0, 0, 0);
    put(OP_SUB, 8'h05, 8'h07, 16'h00FE, 1, 0, 0);
    run_prog(st);
    chk("mul_sub_stall_cycles", st, 8);

    put(OP_NOP, 8'h12, 8'h34, 16'h0000, 0, 0, 0);
    put(4'hE,   8'h56, 8'h78, 16'h0000, 0, 0, 0);
    run_prog(st);
    chk("nop_stall_cycles", st, 0);
    chk("nop_result_held", result, 16'h00FE);
    chk("nop_carry_held", carry, 1);

    put(OP_SUB, 8'h08, 8'h08, 16'h0000, 0, 1, 0);
    put(OP_OR,  8'hA0, 8'h05, 16'h00A5, 0, 0, 0);
    put(OP_XOR, 8'hFF, 8'h0F, 16'h00F0, 0, 0, 0);
    put(OP_SHL, 8'h81, 8'h00, 16'h0002, 0, 0, 0);
    put(OP_SHR, 8'h81, 8'h00, 16'h0040, 0, 0, 0);
    put(OP_ADD, 8'h80, 8'h80, 16'h0000, 1, 1, 0);
    put(OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 0, 0, 0);
    put(OP_DIV, 8'hFF, 8'h01, 16'h00FF, 0, 0, 0);
    put(OP_DIV, 8'h07, 8'd100, 16'h0700, 0, 0, 0);
    run_prog(st);
    chk("mixed_stall_cycles", st, 24);

    // Reset asserted in cycle 4 of a DIV: the op is aborted and never reported
    @(posedge clk); #1;
    opcode = OP_DIV; a = 8'hC3; b = 8'h05;
    @(posedge clk); #1;
    opcode = OP_NOP; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_stall_before_abort", stall, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("abort_stall", stall, 0);
    chk("abort_result", result, 0);
    chk("abort_valid", valid, 0);
    chk("abort_carry", carry, 0);
    chk("abort_zero", zero, 0);
    chk("abort_div0", div0, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_late_result", result, 0);
    chk("abort_stall_after", stall, 0);

    put(OP_AND, 8'h3C, 8'h0F, 16'h000C, 0, 0, 0);
    run_prog(st);
    chk("and_stall_cycles", st, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
